seq_progress_checker: RTL and testbench

Receive-side checker for the saturating progression counter stream: accepts W-bit symbols over a valid/ready handshake, confirms they follow 0, 1, …, 2**W-1 and then hold at 2**W-1, and reports lock or a sticky error. It sits at the consuming end of the counter interface and is the observation block used by formal and simulation benches to prove the producer's sequence property.

---
 rtl/seq_chk_pkg.sv | 16 +
 rtl/seq_idle_timer.sv | 27 ++
 rtl/seq_progress_checker.sv | 126 ++++++++++++
 tb/tb_seq_progress_checker.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_chk_pkg.sv
// Shared types for the progression-stream checker: FSM state encoding and error codes.
package seq_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_START   = 2'd1;
  localparam logic [1:0] ERR_ORDER   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/seq_idle_timer.sv
// Idle-cycle counter: counts inc cycles since the last clear and pulses expired
// combinationally on the inc cycle that brings the count to LIMIT.
module seq_idle_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CW'(LIMIT))) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = inc && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/seq_progress_checker.sv
// Receive-side checker for the saturating 0..MAXV progression stream.
// Optional idle timeout in TRACK is enabled by defining SEQ_CHK_TIMEOUT_EN.
module seq_progress_checker
  import seq_chk_pkg::*;
#(
  parameter int W           = 2,
  parameter int HOLD_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              i_valid,
  input  logic [W-1:0]      i_sym,
  output logic              o_ready,
  output logic              o_locked,
  output logic              o_err,
  output logic [1:0]        o_err_code,
  output logic [HOLD_W-1:0] o_hold_cnt,
  output state_t            o_state
);

  // Handshake: a symbol is consumed on a rising edge where i_valid && o_ready;
  // i_sym is only looked at on that edge, and the producer may hold or change
  // it freely otherwise. o_ready only drops once the checker has entered ERR.

  localparam logic [W-1:0] MAXV = '1;

  state_t            state, state_nx;
  logic [W-1:0]      exp_q, exp_nx;
  logic              locked_nx, err_nx, ready_nx;
  logic [1:0]        code_nx;
  logic [HOLD_W-1:0] hold_nx;
  logic              accept;
  logic              timeout;

  assign accept  = i_valid && o_ready;
  assign o_state = state;

`ifdef SEQ_CHK_TIMEOUT_EN
  seq_idle_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_idle_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr || accept || (state != TRACK)),
    .inc     ((state == TRACK) && !accept),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    exp_nx    = exp_q;
    locked_nx = o_locked;
    code_nx   = o_err_code;
    hold_nx   = o_hold_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (i_sym == '0) begin
            state_nx = TRACK;
            exp_nx   = W'(1);
          end else begin
            state_nx = ERR;
            code_nx  = ERR_START;
          end
        end
      end
      TRACK: begin
        if (accept) begin
          if (i_sym != exp_q) begin
            state_nx = ERR;
            code_nx  = ERR_ORDER;
          end else if (exp_q == MAXV) begin
            state_nx  = DONE;
            locked_nx = 1'b1;
            hold_nx   = '0;
          end else begin
            exp_nx = exp_q + W'(1);
          end
        end else if (timeout) begin
          state_nx = ERR;
          code_nx  = ERR_TIMEOUT;
        end
      end
      DONE: begin
        if (accept) begin
          if (i_sym != MAXV) begin
            state_nx  = ERR;
            code_nx   = ERR_ORDER;
            locked_nx = 1'b0;
          end else if (o_hold_cnt != '1) begin
            hold_nx = o_hold_cnt + HOLD_W'(1);
          end
        end
      end
      default: ;
    endcase
    err_nx   = (state_nx == ERR);
    ready_nx = !err_nx;
  end

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      state      <= IDLE;
      exp_q      <= '0;
      o_ready    <= 1'b1;
      o_locked   <= 1'b0;
      o_err      <= 1'b0;
      o_err_code <= ERR_NONE;
      o_hold_cnt <= '0;
    end else begin
      state      <= state_nx;
      exp_q      <= exp_nx;
      o_ready    <= ready_nx;
      o_locked   <= locked_nx;
      o_err      <= err_nx;
      o_err_code <= code_nx;
      o_hold_cnt <= hold_nx;
    end
  end

endmodule

// File: tb/tb_seq_progress_checker.sv
// Bench for seq_progress_checker: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_seq_progress_checker;
  import seq_chk_pkg::*;

  localparam int W    = 2;
  localparam int HW   = 2;
  localparam int TO   = 4;
  localparam int MAXV = (1 << W) - 1;
  localparam int HMAX = (1 << HW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clr = 1'b0;
  logic          i_valid = 1'b0;
  logic [W-1:0]  i_sym = '0;
  logic          o_ready, o_locked, o_err;
  logic [1:0]    o_err_code;
  logic [HW-1:0] o_hold_cnt;
  state_t        o_state;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  seq_progress_checker #(.W(W), .HOLD_W(HW), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .i_valid    (i_valid),
    .i_sym      (i_sym),
    .o_ready    (o_ready),
    .o_locked   (o_locked),
    .o_err      (o_err),
    .o_err_code (o_err_code),
    .o_hold_cnt (o_hold_cnt),
    .o_state    (o_state)
  );

  always #5 clk = ~clk;

  // Model: position in the sequence, plus flags and counters as plain integers.
  typedef struct {
    int nxt;
    bit locked;
    bit err;
    int code;
    int hold;
    int idle;
  } model_t;

  model_t m = '{default: 0};

  function automatic model_t step(model_t c, bit rst_n, bit cl, bit v, int s);
    model_t n = c;
    if (!rst_n || cl) begin
      n = '{default: 0};
      return n;
    end
    if (c.err) return n;
    if (v) begin
      n.idle = 0;
      if (c.locked) begin
        if (s == MAXV) n.hold = (c.hold < HMAX) ? c.hold + 1 : HMAX;
        else begin n.err = 1; n.code = 2; n.locked = 0; end
      end else if (s == c.nxt) begin
        if (c.nxt == MAXV) begin n.locked = 1; n.hold = 0; end
        else n.nxt = c.nxt + 1;
      end else begin
        n.err  = 1;
        n.code = (c.nxt == 0) ? 1 : 2;
      end
    end
`ifdef SEQ_CHK_TIMEOUT_EN
    else if (!c.locked && c.nxt != 0) begin
      n.idle = c.idle + 1;
      if (n.idle >= TO) begin n.err = 1; n.code = 3; end
    end
`endif
    return n;
  endfunction

  always @(posedge clk) m <= step(m, reset, clr, i_valid, int'(i_sym));

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready",  int'(o_ready), int'(!m.err));
      check("locked", int'(o_locked), int'(m.locked));
      check("err",    int'(o_err), int'(m.err));
      check("code",   int'(o_err_code), m.code);
      check("hold",   int'(o_hold_cnt), m.hold);
      check("excl",   int'(o_locked && o_err), 0);
    end
  end

  task automatic cyc(input bit v, input int s, input bit c = 1'b0);
    @(negedge clk);
    reset   = 1'b1;
    clr     = c;
    i_valid = v;
    i_sym   = W'(s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; clr = 1'b0; i_valid = 1'b0; i_sym = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bit   rv, vv, cv;
    int   sv;
    do_reset();
    chk_en = 1'b1;
    check("rst_ready", int'(o_ready), 1);
    check("rst_code",  int'(o_err_code), 0);

    // Clean run to lock, then hold repeats.
    cyc(1, 0); cyc(1, 1); cyc(1, 2); cyc(1, 3);
    cyc(1, 3);
    check("lock_after_max", int'(o_locked), 1);
    check("hold_first", int'(o_hold_cnt), 0);
    cyc(1, 3);
    cyc(0, 0);
    check("hold_end", int'(o_hold_cnt), 2);
    check("no_err", int'(o_err), 0);

    // Bad start; later symbols ignored.
    do_reset();
    cyc(1, 2); cyc(1, 0);
    check("bad_start_code", int'(o_err_code), 1);
    check("bad_start_rdy", int'(o_ready), 0);
    cyc(1, 1); cyc(0, 0);
    check("err_frozen", int'(o_err_code), 1);

    // Out of order in TRACK, then in DONE.
    do_reset();
    cyc(1, 0); cyc(1, 1); cyc(1, 3); cyc(0, 0);
    check("order_track", int'(o_err_code), 2);
    do_reset();
    cyc(1, 0); cyc(1, 1); cyc(1, 2); cyc(1, 3); cyc(1, 0); cyc(0, 0);
    check("order_done", int'(o_err_code), 2);
    check("order_done_lock", int'(o_locked), 0);

    // Hold saturation, then clr beats a same-cycle accept.
    do_reset();
    cyc(1, 0); cyc(1, 1); cyc(1, 2); cyc(1, 3);
    for (int i = 0; i < 5; i++) cyc(1, 3);
    cyc(0, 0);
    check("hold_sat", int'(o_hold_cnt), HMAX);
    cyc(1, 0, 1'b1); cyc(0, 0);
    check("clr_lock", int'(o_locked), 0);
    check("clr_hold", int'(o_hold_cnt), 0);
    cyc(1, 1); cyc(0, 0);
    check("clr_dropped", int'(o_err_code), 1);

    // Reset mid-sequence.
    do_reset();
    cyc(1, 0); cyc(0, 0); cyc(1, 1); cyc(0, 0);
    @(negedge clk); reset = 1'b0; i_valid = 1'b0;
    cyc(1, 2); cyc(0, 0);
    check("mid_reset", int'(o_err_code), 1);

`ifdef SEQ_CHK_TIMEOUT_EN
    do_reset();
    cyc(1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0);
    check("to_not_yet", int'(o_err), 0);
    cyc(0, 0);
    check("to_code", int'(o_err_code), 3);
    do_reset();
    cyc(1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0);
    cyc(1, 1);
    for (int i = 0; i < 2; i++) cyc(0, 0);
    check("to_accept_wins", int'(o_err), 0);
    cyc(1, 2); cyc(1, 3);
    for (int i = 0; i < 100; i++) cyc(0, 0);
    check("done_no_to", int'(o_err), 0);
    check("done_locked", int'(o_locked), 1);
`endif

    // Randomized traffic, mostly following the sequence.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rv = ($urandom_range(0, 199) != 0);
      cv = ($urandom_range(0, 99) < 2);
      vv = ($urandom_range(0, 99) < 75);
      if ($urandom_range(0, 19) < 18) sv = m.locked ? MAXV : (m.nxt & MAXV);
      else sv = $urandom_range(0, MAXV);
      @(negedge clk);
      reset = rv; clr = cv; i_valid = vv; i_sym = W'(sv);
    end
    cyc(0, 0);
    cyc(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
